// File: rtl/iport_conditioner.sv
// rtl/iport_conditioner.sv - synchronize, debounce and edge-capture raw board inputs
module iport_conditioner #(
  parameter int WIDTH          = 32,
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_wd,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] rise_latch,
  output logic             any_event
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // history holds the older samples; the live sync2 value is the last vote
  localparam int HW = STABLE_SAMPLES - 1;
  localparam logic [CW-1:0] LP_LAST = CW'(TICK_DIV - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hist [HW];
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_pulse;
  logic [WIDTH-1:0] r_latch;
  logic             r_any;

  logic             w_tick;
  logic [WIDTH-1:0] w_all1;
  logic [WIDTH-1:0] w_all0;
  logic [WIDTH-1:0] w_db_next;
  logic [WIDTH-1:0] w_rise_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_latch_next;

  assign w_tick     = (r_cnt == LP_LAST);
  assign db_out     = r_db;
  assign rise_pulse = r_pulse;
  assign rise_latch = r_latch;
  assign any_event  = r_any;

  // two-flop synchronizer for the asynchronous raw inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // free-running prescaler shared by all bits, wraps after TICK_DIV-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // sample history, index 0 is the newest sample, shifted only on ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < HW; i++) r_hist[i] <= '0;
    end else if (w_tick) begin
      r_hist[0] <= r_sync2;
      for (int i = 1; i < HW; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  // agreement vote, next debounced level, rise detection and latch update
  always_comb begin
    w_all1 = r_sync2;
    w_all0 = ~r_sync2;
    for (int i = 0; i < HW; i++) begin
      w_all1 = w_all1 & r_hist[i];
      w_all0 = w_all0 & ~r_hist[i];
    end
    w_db_next    = w_tick ? ((r_db | w_all1) & ~w_all0) : r_db;
    w_rise_set   = w_db_next & ~r_db;
    w_clr        = clr_we ? clr_wd : '0;
    // set is OR-ed in after the clear so a same-cycle rise wins
    w_latch_next = (r_latch & ~w_clr) | w_rise_set;
  end

  // registered outputs; any_event tracks the next latch value so it stays aligned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db    <= '0;
      r_pulse <= '0;
      r_latch <= '0;
      r_any   <= 1'b0;
    end else begin
      r_db    <= w_db_next;
      r_pulse <= w_rise_set;
      r_latch <= w_latch_next;
      r_any   <= |w_latch_next;
    end
  end

endmodule

// File: tb/tb_iport_conditioner.sv
// tb/tb_iport_conditioner.sv - directed self-checking bench for iport_conditioner
module tb_iport_conditioner;

  logic       clk;
  logic       reset_n;
  logic [7:0] raw_in;
  logic       clr_we;
  logic [7:0] clr_wd;
  logic [7:0] db_out;
  logic [7:0] rise_pulse;
  logic [7:0] rise_latch;
  logic       any_event;

  int checks;
  int errors;
  int ncyc;

  iport_conditioner #(
    .WIDTH(8),
    .TICK_DIV(4),
    .STABLE_SAMPLES(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_in(raw_in),
    .clr_we(clr_we),
    .clr_wd(clr_wd),
    .db_out(db_out),
    .rise_pulse(rise_pulse),
    .rise_latch(rise_latch),
    .any_event(any_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int bad_out;
    int bad_tick;
    int j;
    int found;
    int pulses;
    int bad;
    int t;
    int n0;

    checks = 0;
    errors = 0;
    ncyc = 0;
    reset_n = 1'b0;
    raw_in = 8'h00;
    clr_we = 1'b0;
    clr_wd = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_db", db_out, 8'h00);
    chk("reset_pulse", rise_pulse, 8'h00);
    chk("reset_latch", rise_latch, 8'h00);
    chk("reset_any", any_event, 1'b0);

    reset_n = 1'b1;
    ncyc = 0;

    // idle: outputs stay zero, tick high when count reaches 3
    bad_out = 0;
    bad_tick = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (db_out !== 8'h00 || rise_pulse !== 8'h00 || rise_latch !== 8'h00 || any_event !== 1'b0)
        bad_out++;
      if (dut.w_tick !== ((ncyc % 4) == 3)) bad_tick++;
    end
    chk("idle_outputs", bad_out, 0);
    chk("tick_period", bad_tick, 0);

    // clean step on bit 0
    raw_in[0] = 1'b1;
    j = 0;
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      step();
      if (db_out[0] === 1'b1) begin
        found = 1;
        j = i;
      end
    end
    chk("step_rise_window", (j >= 11 && j <= 14), 1'b1);
    chk("step_pulse_on", rise_pulse, 8'h01);
    chk("step_latch", rise_latch, 8'h01);
    chk("step_any", any_event, 1'b1);
    step();
    chk("step_pulse_off", rise_pulse, 8'h00);
    repeat (5) step();
    chk("step_latch_hold", rise_latch, 8'h01);
    chk("step_any_hold", any_event, 1'b1);
    chk("step_db_hold", db_out, 8'h01);

    // release bit 0: falling level, no pulse, latch sticky
    raw_in[0] = 1'b0;
    found = 0;
    pulses = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      step();
      if (rise_pulse !== 8'h00) pulses++;
      if (db_out[0] === 1'b0) found = 1;
    end
    chk("fall_seen", found, 1);
    chk("fall_no_pulse", pulses, 0);
    chk("fall_latch_kept", rise_latch, 8'h01);

    // 7-cycle glitch on bit 3 at each of the four tick phases
    for (int ph = 0; ph < 4; ph++) begin
      bad = 0;
      raw_in[3] = 1'b1;
      for (int i = 0; i < 28; i++) begin
        step();
        if (i == 6) raw_in[3] = 1'b0;
        if (db_out[3] !== 1'b0 || rise_pulse[3] !== 1'b0 || rise_latch[3] !== 1'b0) bad++;
      end
      chk($sformatf("glitch_ph%0d", ph), bad, 0);
      step();
    end

    // raise bit 2 so the latch reads 05
    raw_in[2] = 1'b1;
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      step();
      if (db_out[2] === 1'b1) found = 1;
    end
    chk("b2_rise_seen", found, 1);
    chk("latch_05", rise_latch, 8'h05);
    chk("any_05", any_event, 1'b1);

    // mask ignored without the strobe
    clr_wd = 8'hFF;
    step();
    clr_wd = 8'h00;
    chk("clr_wd_ignored", rise_latch, 8'h05);

    clr_we = 1'b1;
    clr_wd = 8'h01;
    step();
    clr_we = 1'b0;
    clr_wd = 8'h00;
    chk("clr_01_latch", rise_latch, 8'h04);
    chk("clr_01_any", any_event, 1'b1);

    clr_we = 1'b1;
    clr_wd = 8'h04;
    step();
    clr_we = 1'b0;
    clr_wd = 8'h00;
    chk("clr_04_latch", rise_latch, 8'h00);
    chk("clr_04_any", any_event, 1'b0);

    // collision: clear-all held while bit 2 rises again
    raw_in[2] = 1'b0;
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      step();
      if (db_out[2] === 1'b0) found = 1;
    end
    chk("b2_fall_seen", found, 1);
    clr_we = 1'b1;
    clr_wd = 8'hFF;
    raw_in[2] = 1'b1;
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      step();
      if (db_out[2] === 1'b1) found = 1;
    end
    clr_we = 1'b0;
    clr_wd = 8'h00;
    chk("coll_rise_seen", found, 1);
    chk("coll_pulse", rise_pulse, 8'h04);
    chk("coll_latch", rise_latch, 8'h04);
    chk("coll_any", any_event, 1'b1);
    step();
    chk("coll_latch_hold", rise_latch, 8'h04);

    // async reset after two agreeing samples of bit 1
    raw_in[1] = 1'b1;
    n0 = ncyc;
    t = 0;
    for (int i = 0; i < 20 && t < 2; i++) begin
      step();
      if (ncyc >= n0 + 3 && (ncyc % 4) == 0) t++;
    end
    step();
    chk("pre_reset_db", db_out, 8'h04);
    reset_n = 1'b0;
    #2;
    chk("async_db", db_out, 8'h00);
    chk("async_pulse", rise_pulse, 8'h00);
    chk("async_latch", rise_latch, 8'h00);
    chk("async_any", any_event, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ncyc = 0;
    j = 0;
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      step();
      if (db_out[1] === 1'b1) begin
        found = 1;
        j = i;
      end
    end
    chk("rst_rise_window", (j >= 11 && j <= 14), 1'b1);
    chk("rst_db", db_out, 8'h06);
    chk("rst_pulse", rise_pulse, 8'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
